multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle sequencer for the MIPS datapath. It replaces the single-cycle CONTROL decode with a per-instruction state machine.
- It drives PC, instruction-register, memory, ALU and register-file enables one phase at a time, so one ALU and one unified memory are shared across cycles.
- It stalls on a memory-ready handshake, traps illegal opcodes, and keeps cycle and retired-instruction counters for the bench.

Parameters:
- CNT_W, 32, width of cycle_count and instr_count.
- MEM_WAIT_EN, 1, 1 = honour mem_ready; 0 = treat memory as always ready (single-cycle access).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- run  in  1  sampled only in FETCH; 0 holds the FSM in FETCH with no memory request.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  load the instruction register.
- mem_to_reg  out  1  write-back select: 1 = MDR, 0 = ALUOut.
- reg_dst  out  1  destination select: 1 = rd, 0 = rt.
- reg_write  out  1  register-file write enable.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B select: 00 = rt, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_op  out  2  to ALUControl: 00 = add, 01 = sub, 10 = funct.
- pc_source  out  2  PC select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- trap  out  1  sticky; set on an illegal opcode.
- state_o  out  4  current state, for debug.
- cycle_count  out  CNT_W  clocks since reset.
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- Reset: state = FETCH, trap = 0, both counters = 0. Every output not listed for FETCH is 0 during reset and in the cycle after it. Reset mid-instruction abandons the instruction with no PC or register write.
- Outputs are Moore, decoded from the state register, except that ir_write, pc_write and the FETCH/MEM exits are gated by rdy. rdy = mem_ready when MEM_WAIT_EN = 1, else 1.
- State encodings live in the package: FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_RD = 3, MEM_WB = 4, MEM_WR = 5, EXEC_R = 6, WB_R = 7, BRANCH = 8, JUMP = 9, EXEC_I = 10, WB_I = 11, TRAP = 12.
- FETCH:
  - run = 0: all outputs 0, stay in FETCH.
  - run = 1: mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - rdy = 1 additionally asserts ir_write = 1 and pc_write = 1 and moves to DECODE. Otherwise stay in FETCH with mem_read held.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target into ALUOut). Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEM_ADDR.
  - 000000 (R-type) -> EXEC_R.
  - 000100 (beq) -> BRANCH.
  - 000010 (j) -> JUMP.
  - 001000 (addi) -> EXEC_I.
  - any other opcode -> TRAP.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next: lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: mem_read = 1, i_or_d = 1. rdy -> MEM_WB, else hold.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. -> FETCH; retires.
- MEM_WR: mem_write = 1, i_or_d = 1. rdy -> FETCH and retires, else hold with mem_write held.
- EXEC_R: alu_src_a = 1, alu_src_b = 00, alu_op = 10. -> WB_R.
- WB_R: reg_write = 1, reg_dst = 1, mem_to_reg = 0. -> FETCH; retires.
- EXEC_I: alu_src_a = 1, alu_src_b = 10, alu_op = 00. -> WB_I.
- WB_I: reg_write = 1, reg_dst = 0, mem_to_reg = 0. -> FETCH; retires.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01. -> FETCH; retires whether or not the branch is taken.
- JUMP: pc_write = 1, pc_source = 10. -> FETCH; retires.
- TRAP: trap = 1 (sticky), all enables 0, stays in TRAP until rst.
- Latencies with rdy always 1: lw = 5, sw = 4, R-type = 4, addi = 4, beq = 3, j = 3 cycles.
- Counters:
  - cycle_count increments every cycle rst = 0, including stall cycles and TRAP.
  - instr_count increments on the retire cycle only.
  - Both wrap modulo 2^CNT_W with no saturation.
- Invariant: mem_read and mem_write are never both 1.

Decomposition:
- mc_pkg holds: state enum (4-bit), opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI), alu_op codes, alu_src_b and pc_source encodings.
- One sub-module, mc_perf_counters, holds the two counters. Inputs: clk, rst, retire. Outputs: cycle_count, instr_count.
- The FSM next-state logic and output decode stay in the top module.

Test Plan:
- Reset, run = 1, mem_ready = 1, opcode = 000000 -> states 0,1,6,7,0. WB_R drives reg_write = 1 and reg_dst = 1. instr_count = 1 and cycle_count = 4 at the next FETCH.
- lw (100011) with mem_ready low for 2 cycles in FETCH and 3 cycles in MEM_RD -> ir_write pulses exactly once. Completes in 10 cycles. mem_read stays asserted throughout both stalls.
- beq (000100) with zero = 1, then again with zero = 0 -> both spend 3 cycles. pc_write_cond = 1 and pc_source = 01 in BRANCH. instr_count = 2.
- Opcode 111111 -> TRAP after DECODE. trap = 1. All enables 0 for 20 cycles while cycle_count keeps incrementing. rst clears trap and returns state_o = 0.
- Assert rst during MEM_WR with mem_write = 1 -> the next cycle has state FETCH, mem_write = 0, and counters = 0.
- run = 0 for 5 cycles after reset -> FSM stays in FETCH with mem_read = 0, cycle_count = 5, instr_count = 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control sequencer.
package mc_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecR   = 4'd6,
    StWbR     = 4'd7,
    StBranch  = 4'd8,
    StJump    = 4'd9,
    StExecI   = 4'd10,
    StWbI     = 4'd11,
    StTrap    = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // First execute state for an opcode; unknown opcodes trap.
  function automatic state_e decode_next(input logic [5:0] op);
    state_e nxt;
    case (op)
      OP_LW, OP_SW: nxt = StMemAddr;
      OP_RTYPE:     nxt = StExecR;
      OP_BEQ:       nxt = StBranch;
      OP_J:         nxt = StJump;
      OP_ADDI:      nxt = StExecI;
      default:      nxt = StTrap;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_perf_counters.sv
// Free-running cycle counter and retired-instruction counter, both wrapping.
module mc_perf_counters #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             retire,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  logic [CNT_W-1:0] cycle_q, instr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_q + CNT_W'(1);
      if (retire) instr_q <= instr_q + CNT_W'(1);
    end
  end

  assign cycle_count = cycle_q;
  assign instr_count = instr_q;

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences one shared ALU and unified memory per phase.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter bit          MEM_WAIT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             trap,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  state_e state_q, state_d;
  logic   trap_q;
  logic   rdy;
  logic   retire;

  // The branch decision is made by the datapath from pc_write_cond and zero.
  logic unused_zero;
  assign unused_zero = zero;

  assign rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:   if (run && rdy) state_d = StDecode;
      StDecode:  state_d = decode_next(opcode);
      StMemAddr: state_d = (opcode == OP_LW) ? StMemRd : StMemWr;
      StMemRd:   if (rdy) state_d = StMemWb;
      StMemWr:   if (rdy) state_d = StFetch;
      StExecR:   state_d = StWbR;
      StExecI:   state_d = StWbI;
      StMemWb, StWbR, StWbI, StBranch, StJump: state_d = StFetch;
      StTrap:    state_d = StTrap;
      default:   state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == StTrap) trap_q <= 1'b1;
    end
  end

  // Enables are masked while rst is high so an abandoned instruction writes nothing.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    if (!rst) begin
      unique case (state_q)
        StFetch: begin
          if (run) begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            ir_write  = rdy;
            pc_write  = rdy;
          end
        end
        StDecode:  alu_src_b = SRCB_IMM_SH;
        StMemAddr: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        StMemRd: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        StMemWb: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        StMemWr: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        StExecR: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        StWbR: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        StExecI: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        StWbI:     reg_write = 1'b1;
        StBranch: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
        end
        StJump: begin
          pc_write  = 1'b1;
          pc_source = PCSRC_JUMP;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    retire = 1'b0;
    if (!rst) begin
      retire = (state_q inside {StMemWb, StWbR, StWbI, StBranch, StJump}) ||
               (state_q == StMemWr && rdy);
    end
  end

  assign trap    = trap_q;
  assign state_o = state_q;

  mc_perf_counters #(
    .CNT_W(CNT_W)
  ) u_perf_counters (
    .clk         (clk),
    .rst         (rst),
    .retire      (retire),
    .cycle_count (cycle_count),
    .instr_count (instr_count)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed per-cycle expectations, negedge monitor.
module tb_multicycle_control;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_RD = 4'd3;
  localparam logic [3:0] S_MEM_WB = 4'd4, S_MEM_WR = 4'd5, S_EXEC_R = 4'd6, S_WB_R = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8, S_JUMP = 4'd9, S_EXEC_I = 4'd10, S_WB_I = 4'd11;
  localparam logic [3:0] S_TRAP = 4'd12;

  localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_SW = 6'b101011;
  localparam logic [5:0] O_BEQ = 6'b000100, O_J = 6'b000010, O_ADDI = 6'b001000;
  localparam logic [5:0] O_BAD = 6'b111111;

  // Outputs that must be low while rst is asserted (not driven by FETCH).
  localparam logic [16:0] RST_MASK = 17'b01001011110000000;

  logic        clk = 1'b0;
  logic        rst, run, zero, mem_ready;
  logic [5:0]  opcode;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, trap;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state_o;
  logic [31:0] cycle_count, instr_count;

  multicycle_control #(
    .CNT_W       (32),
    .MEM_WAIT_EN (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .trap          (trap),
    .state_o       (state_o),
    .cycle_count   (cycle_count),
    .instr_count   (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] ctrl;
    logic [31:0] cyc;
    logic [31:0] ins;
    bit          in_rst;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_cyc = 0;
  logic [31:0] exp_ins = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // Expected control vector for a state, straight from the state output table.
  function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic r, input logic rdy);
    logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, tr;
    logic [1:0] sbv, ao, ps;
    {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, tr} = '0;
    sbv = 2'b00; ao = 2'b00; ps = 2'b00;
    case (st)
      S_FETCH:    if (r) begin mr = 1; sbv = 2'b01; if (rdy) begin irw = 1; pw = 1; end end
      S_DECODE:   sbv = 2'b11;
      S_MEM_ADDR: begin sa = 1; sbv = 2'b10; end
      S_MEM_RD:   begin mr = 1; iod = 1; end
      S_MEM_WB:   begin rw = 1; m2r = 1; end
      S_MEM_WR:   begin mw = 1; iod = 1; end
      S_EXEC_R:   begin sa = 1; ao = 2'b10; end
      S_WB_R:     begin rw = 1; rd = 1; end
      S_BRANCH:   begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
      S_JUMP:     begin pw = 1; ps = 2'b10; end
      S_EXEC_I:   begin sa = 1; sbv = 2'b10; end
      S_WB_I:     rw = 1;
      S_TRAP:     tr = 1;
      default: ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sbv, ao, ps, tr};
  endfunction

  // One clock of stimulus; ret marks the cycle on which an instruction retires.
  task automatic step(input logic r, input logic [5:0] op, input logic mr, input logic z,
                      input logic [3:0] st, input bit ret);
    exp_t e;
    run = r; opcode = op; mem_ready = mr; zero = z;
    e.st = st; e.ctrl = exp_ctrl(st, r, mr); e.cyc = exp_cyc; e.ins = exp_ins; e.in_rst = 0;
    sb_q.push_back(e);
    @(posedge clk); #1;
    exp_cyc++;
    if (ret) exp_ins++;
  endtask

  task automatic do_reset(input bit chk_rst);
    exp_t e;
    rst = 1'b1;
    if (chk_rst) begin
      e.st = 0; e.ctrl = 0; e.cyc = 0; e.ins = 0; e.in_rst = 1;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cyc = 0;
    exp_ins = 0;
  endtask

  logic [16:0] act_ctrl;
  assign act_ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                     reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, trap};

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("mem_rd_wr_exclusive", 32'(mem_read & mem_write), 32'd0);
        if (e.in_rst) begin
          chk("enables_in_reset", 32'(act_ctrl & RST_MASK), 32'd0);
        end else begin
          chk("state", 32'(state_o), 32'(e.st));
          chk("ctrl", 32'(act_ctrl), 32'(e.ctrl));
          chk("cycle_count", cycle_count, e.cyc);
          chk("instr_count", instr_count, e.ins);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog t=%0t got=running expected=finished", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1; run = 0; opcode = O_R; mem_ready = 0; zero = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // R-type, addi, sw, j back to back with memory always ready
    step(1, O_R, 1, 0, S_FETCH, 0);     step(1, O_R, 1, 0, S_DECODE, 0);
    step(1, O_R, 1, 0, S_EXEC_R, 0);    step(1, O_R, 1, 0, S_WB_R, 1);
    step(1, O_ADDI, 1, 0, S_FETCH, 0);  step(1, O_ADDI, 1, 0, S_DECODE, 0);
    step(1, O_ADDI, 1, 0, S_EXEC_I, 0); step(1, O_ADDI, 1, 0, S_WB_I, 1);
    step(1, O_SW, 1, 0, S_FETCH, 0);    step(1, O_SW, 1, 0, S_DECODE, 0);
    step(1, O_SW, 1, 0, S_MEM_ADDR, 0); step(1, O_SW, 1, 0, S_MEM_WR, 1);
    step(1, O_J, 1, 0, S_FETCH, 0);     step(1, O_J, 1, 0, S_DECODE, 0);
    step(1, O_J, 1, 0, S_JUMP, 1);
    step(0, O_R, 1, 0, S_FETCH, 0);

    // lw with 2 fetch stalls and 3 read stalls: 10 cycles
    do_reset(0);
    step(1, O_LW, 0, 0, S_FETCH, 0);    step(1, O_LW, 0, 0, S_FETCH, 0);
    step(1, O_LW, 1, 0, S_FETCH, 0);    step(1, O_LW, 0, 0, S_DECODE, 0);
    step(1, O_LW, 0, 0, S_MEM_ADDR, 0);
    for (int i = 0; i < 3; i++) step(1, O_LW, 0, 0, S_MEM_RD, 0);
    step(1, O_LW, 1, 0, S_MEM_RD, 0);   step(1, O_LW, 0, 0, S_MEM_WB, 1);
    step(0, O_LW, 1, 0, S_FETCH, 0);

    // beq taken then not taken
    do_reset(0);
    step(1, O_BEQ, 1, 1, S_FETCH, 0);   step(1, O_BEQ, 1, 1, S_DECODE, 0);
    step(1, O_BEQ, 1, 1, S_BRANCH, 1);
    step(1, O_BEQ, 1, 0, S_FETCH, 0);   step(1, O_BEQ, 1, 0, S_DECODE, 0);
    step(1, O_BEQ, 1, 0, S_BRANCH, 1);
    step(0, O_BEQ, 1, 0, S_FETCH, 0);

    // illegal opcode traps and stays trapped until reset
    do_reset(0);
    step(1, O_BAD, 1, 0, S_FETCH, 0);   step(1, O_BAD, 1, 0, S_DECODE, 0);
    for (int i = 0; i < 20; i++) step(1, O_BAD, 1, 0, S_TRAP, 0);
    do_reset(0);
    step(0, O_R, 1, 0, S_FETCH, 0);

    // reset asserted while a store is stalled in MEM_WR
    do_reset(0);
    step(1, O_SW, 1, 0, S_FETCH, 0);    step(1, O_SW, 1, 0, S_DECODE, 0);
    step(1, O_SW, 1, 0, S_MEM_ADDR, 0); step(1, O_SW, 0, 0, S_MEM_WR, 0);
    do_reset(1);
    step(1, O_R, 1, 0, S_FETCH, 0);

    // run held low: idle in FETCH with no memory request
    do_reset(0);
    for (int i = 0; i < 6; i++) step(0, O_LW, 1, 0, S_FETCH, 0);

    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
